// File: rtl/parafuzz_pkg.sv
// Shared marker definitions for the phase sync tracker: marker encodings,
// phase enumeration and the commit-lane marker decoder.
package parafuzz_pkg;

    localparam logic [31:0] MK_VCTM_START  = 32'h0000_2013;
    localparam logic [31:0] MK_VCTM_END    = 32'h0010_2013;
    localparam logic [31:0] MK_DELAY_START = 32'h0020_2013;
    localparam logic [31:0] MK_DELAY_END   = 32'h0030_2013;
    localparam logic [31:0] MK_TEXE_START  = 32'h0040_2013;
    localparam logic [31:0] MK_TEXE_END    = 32'h0050_2013;
    localparam logic [31:0] MK_LEAK_START  = 32'h0060_2013;
    localparam logic [31:0] MK_LEAK_END    = 32'h0070_2013;
    localparam logic [31:0] MK_INIT_START  = 32'h0080_2013;
    localparam logic [31:0] MK_INIT_END    = 32'h0090_2013;
    localparam logic [31:0] MK_BIM_START   = 32'h00A0_2013;
    localparam logic [31:0] MK_BIM_END     = 32'h00B0_2013;
    localparam logic [31:0] MK_TRAIN_START = 32'h00C0_2013;
    localparam logic [31:0] MK_TRAIN_END   = 32'h00D0_2013;

    typedef enum logic [2:0] {
        PH_VCTM  = 3'd0,
        PH_DELAY = 3'd1,
        PH_TEXE  = 3'd2,
        PH_LEAK  = 3'd3,
        PH_INIT  = 3'd4,
        PH_BIM   = 3'd5,
        PH_TRAIN = 3'd6,
        PH_NONE  = 3'd7
    } phase_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } marker_t;

    // code[0] distinguishes START (0) from END (1); code[3:1] is the phase
    function automatic marker_t decode_marker(input logic valid, input logic [31:0] inst);
        marker_t m;
        m.hit  = valid && (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013)
                 && (inst[23:20] <= 4'd13);
        m.code = inst[23:20];
        return m;
    endfunction

endpackage

// File: rtl/marker_fifo.sv
// Per-side marker queue; a push into a full queue is accepted only when a
// pop happens in the same cycle, otherwise it is dropped and flagged.
module marker_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             accept;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_ok   = pop && !empty;
    assign accept   = push && (!full || pop_ok);
    assign overflow = push && full && !pop_ok;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/phase_sync_tracker.sv
// Tracks phase markers committed by the DUT and variant lanes, pairs them up
// and reports matches/errors. Define PARAFUZZ_LAG_TIMEOUT_EN to enable the lag timeout.
module phase_sync_tracker
    import parafuzz_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LAG_MAX    = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dut_valid,
    input  logic [31:0]      dut_inst,
    input  logic             vnt_valid,
    input  logic [31:0]      vnt_inst,
    output logic [2:0]       dut_phase,
    output logic [2:0]       vnt_phase,
    output logic             sync,
    output logic             evt_valid,
    output logic [3:0]       evt_code,
    output logic [CNT_W-1:0] evt_len,
    output logic             err_diverge,
    output logic             err_proto,
    output logic             err_overflow,
    output logic             err_timeout
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LAG_MAX == 0 || CNT_W == 0)
    begin : g_param_check
        $error("phase_sync_tracker: unsupported parameter set");
    end

    marker_t          dut_m;
    marker_t          vnt_m;
    phase_e           dut_phase_q;
    phase_e           vnt_phase_q;
    logic             dut_ok;
    logic             vnt_ok;
    logic [CNT_W-1:0] dut_cnt;
    logic [CNT_W-1:0] dut_cnt_next;
    logic [CNT_W+3:0] dut_din;
    logic [CNT_W+3:0] dut_head;
    logic [3:0]       vnt_head;
    logic             dut_empty, dut_full, dut_ovf;
    logic             vnt_empty, vnt_full, vnt_ovf;
    logic             pop;
    logic             match;
    logic             mismatch;

    assign dut_m = decode_marker(dut_valid, dut_inst);
    assign vnt_m = decode_marker(vnt_valid, vnt_inst);

    always_comb begin
        dut_ok = dut_m.code[0] ? (dut_phase_q == phase_e'(dut_m.code[3:1])) : (dut_phase_q == PH_NONE);
        vnt_ok = vnt_m.code[0] ? (vnt_phase_q == phase_e'(vnt_m.code[3:1])) : (vnt_phase_q == PH_NONE);
    end

    always_comb begin
        dut_cnt_next = dut_cnt;
        if (dut_m.hit && !dut_m.code[0]) begin
            dut_cnt_next = '0;
        end else if (dut_phase_q != PH_NONE && dut_cnt != '1) begin
            dut_cnt_next = dut_cnt + CNT_W'(1);
        end
    end

    // DUT entries carry the phase length as of the END commit, so the value
    // survives however long the variant lags behind.
    assign dut_din = {(dut_m.code[0] ? dut_cnt_next : '0), dut_m.code};

    marker_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CNT_W + 4)) u_dut_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (dut_m.hit),
        .pop      (pop),
        .din      (dut_din),
        .dout     (dut_head),
        .empty    (dut_empty),
        .full     (dut_full),
        .overflow (dut_ovf)
    );

    marker_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_vnt_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (vnt_m.hit),
        .pop      (pop),
        .din      (vnt_m.code),
        .dout     (vnt_head),
        .empty    (vnt_empty),
        .full     (vnt_full),
        .overflow (vnt_ovf)
    );

    assign pop      = !dut_empty && !vnt_empty;
    assign match    = pop && (dut_head[3:0] == vnt_head);
    assign mismatch = pop && (dut_head[3:0] != vnt_head);

    always_ff @(posedge clock) begin
        if (!reset) begin
            dut_phase_q  <= PH_NONE;
            vnt_phase_q  <= PH_NONE;
            dut_cnt      <= '0;
            evt_valid    <= 1'b0;
            evt_code     <= '0;
            evt_len      <= '0;
            err_diverge  <= 1'b0;
            err_proto    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (dut_m.hit && dut_ok) begin
                dut_phase_q <= dut_m.code[0] ? PH_NONE : phase_e'(dut_m.code[3:1]);
            end
            if (vnt_m.hit && vnt_ok) begin
                vnt_phase_q <= vnt_m.code[0] ? PH_NONE : phase_e'(vnt_m.code[3:1]);
            end
            dut_cnt      <= dut_cnt_next;
            evt_valid    <= match;
            evt_code     <= match ? vnt_head : '0;
            evt_len      <= (match && vnt_head[0]) ? dut_head[CNT_W+3:4] : '0;
            err_diverge  <= err_diverge | mismatch;
            err_proto    <= err_proto | (dut_m.hit && !dut_ok) | (vnt_m.hit && !vnt_ok);
            err_overflow <= err_overflow | dut_ovf | vnt_ovf;
        end
    end

`ifdef PARAFUZZ_LAG_TIMEOUT_EN
    localparam int unsigned LAG_W = $clog2(LAG_MAX + 1);

    logic [LAG_W-1:0] lag_cnt;
    logic             err_timeout_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            lag_cnt       <= '0;
            err_timeout_q <= 1'b0;
        end else if (dut_empty != vnt_empty) begin
            if (lag_cnt < LAG_W'(LAG_MAX)) begin
                lag_cnt <= lag_cnt + 1'b1;
            end
            if (lag_cnt == LAG_W'(LAG_MAX - 1)) begin
                err_timeout_q <= 1'b1;
            end
        end else begin
            lag_cnt <= '0;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign dut_phase = dut_phase_q;
    assign vnt_phase = vnt_phase_q;
    assign sync      = dut_empty && vnt_empty && (dut_phase_q == vnt_phase_q) && !err_diverge;

endmodule

// File: tb/tb_phase_sync_tracker.sv
// Directed bench for phase_sync_tracker with an event scoreboard.
module tb_phase_sync_tracker;
    import parafuzz_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        dut_valid, vnt_valid;
    logic [31:0] dut_inst, vnt_inst;
    logic [2:0]  dut_phase, vnt_phase;
    logic        sync, evt_valid;
    logic [3:0]  evt_code;
    logic [31:0] evt_len;
    logic        err_diverge, err_proto, err_overflow, err_timeout;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] len;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    phase_sync_tracker #(.FIFO_DEPTH(4), .LAG_MAX(16), .CNT_W(32)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .dut_valid    (dut_valid),
        .dut_inst     (dut_inst),
        .vnt_valid    (vnt_valid),
        .vnt_inst     (vnt_inst),
        .dut_phase    (dut_phase),
        .vnt_phase    (vnt_phase),
        .sync         (sync),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_len      (evt_len),
        .err_diverge  (err_diverge),
        .err_proto    (err_proto),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [31:0] inst);
        return inst[23:20];
    endfunction

    function automatic void push_exp(input logic [3:0] code, input logic [31:0] len,
                                     input int unsigned at);
        exp_t e;
        e.code = code;
        e.len  = len;
        e.cyc  = at;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) tick();
    endtask

    task automatic drive(input logic dv, input logic [31:0] di, input logic vv, input logic [31:0] vi);
        dut_valid = dv;
        dut_inst  = di;
        vnt_valid = vv;
        vnt_inst  = vi;
        tick();
        dut_valid = 1'b0;
        vnt_valid = 1'b0;
    endtask

    task automatic do_reset();
        chk("sb_pending_before_reset", 64'(sb.size()), 64'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dut_phase"}, 64'(dut_phase), 64'd7);
        chk({tag, "_vnt_phase"}, 64'(vnt_phase), 64'd7);
        chk({tag, "_sync"}, 64'(sync), 64'd1);
        chk({tag, "_errs"}, 64'({err_diverge, err_proto, err_overflow, err_timeout}), 64'd0);
    endtask

    // Scoreboard: every evt_valid pulse must match the oldest expectation
    always @(negedge clock) begin
        if (evt_valid) begin
            if (sb.size() == 0) begin
                chk("evt_unexpected", 64'(evt_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("evt_code", 64'(evt_code), 64'(e.code));
                chk("evt_len", 64'(evt_len), 64'(e.len));
                chk("evt_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [31:0] mk[5];
        int unsigned td[5];
        int unsigned t, t2, p;

        mk[0] = MK_VCTM_START;
        mk[1] = MK_VCTM_END;
        mk[2] = MK_DELAY_START;
        mk[3] = MK_DELAY_END;
        mk[4] = MK_TEXE_START;

        // Reset with commits present: they must be ignored
        reset     = 1'b0;
        dut_valid = 1'b1;
        dut_inst  = MK_INIT_START;
        vnt_valid = 1'b1;
        vnt_inst  = MK_LEAK_START;
        repeat (3) tick();
        reset     = 1'b1;
        dut_valid = 1'b0;
        vnt_valid = 1'b0;
        chk_idle("reset");
        chk("reset_evt", 64'({evt_valid, evt_code, evt_len}), 64'd0);
        repeat (2) tick();

        // Simultaneous INIT START, then INIT END
        t = cyc;
        push_exp(code_of(MK_INIT_START), 32'd0, t + 2);
        drive(1'b1, MK_INIT_START, 1'b1, MK_INIT_START);
        chk("init_dut_phase", 64'(dut_phase), 64'd4);
        chk("init_vnt_phase", 64'(vnt_phase), 64'd4);
        chk("init_sync_pending", 64'(sync), 64'd0);
        tick();
        chk("init_sync", 64'(sync), 64'd1);
        t2 = cyc;
        push_exp(code_of(MK_INIT_END), 32'(t2 - t), t2 + 2);
        drive(1'b1, MK_INIT_END, 1'b1, MK_INIT_END);
        repeat (3) tick();
        chk_idle("init_end");

        // Variant lags the DUT
        t = cyc;
        drive(1'b1, MK_VCTM_START, 1'b0, 32'd0);
        chk("lag_sync", 64'(sync), 64'd0);
        wait_until(t + 3);
        push_exp(code_of(MK_VCTM_START), 32'd0, t + 5);
        drive(1'b0, 32'd0, 1'b1, MK_VCTM_START);
        wait_until(t + 50);
        t2 = cyc;
        drive(1'b1, MK_VCTM_END, 1'b0, 32'd0);
        wait_until(t + 55);
        push_exp(code_of(MK_VCTM_END), 32'(t2 - t), t + 57);
        drive(1'b0, 32'd0, 1'b1, MK_VCTM_END);
        repeat (4) tick();
        chk_idle("lag_end");

        // Fill the DUT queue, then push into it while it is being popped
        for (int i = 0; i < 4; i++) begin
            td[i] = cyc;
            drive(1'b1, mk[i], 1'b0, 32'd0);
        end
        push_exp(code_of(mk[0]), 32'd0, cyc + 2);
        drive(1'b0, 32'd0, 1'b1, mk[0]);
        td[4] = cyc;
        push_exp(code_of(mk[1]), 32'(td[1] - td[0]), cyc + 2);
        drive(1'b1, mk[4], 1'b1, mk[1]);
        for (int i = 2; i < 5; i++) begin
            push_exp(code_of(mk[i]), (i % 2 == 1) ? 32'(td[i] - td[i-1]) : 32'd0, cyc + 2);
            drive(1'b0, 32'd0, 1'b1, mk[i]);
        end
        repeat (3) tick();
        chk("full_pop_overflow", 64'(err_overflow), 64'd0);
        chk("full_pop_dut_phase", 64'(dut_phase), 64'd2);
        chk("full_pop_vnt_phase", 64'(vnt_phase), 64'd2);
        chk("full_pop_sync", 64'(sync), 64'd1);
        do_reset();
        chk_idle("reset2");

        // Overflow on the fifth unmatched marker, lag timeout
        p = cyc;
        for (int i = 0; i < 4; i++) drive(1'b1, mk[i], 1'b0, 32'd0);
        chk("ovf_before", 64'(err_overflow), 64'd0);
        drive(1'b1, mk[4], 1'b0, 32'd0);
        chk("ovf_after", 64'(err_overflow), 64'd1);
        chk("ovf_proto", 64'(err_proto), 64'd0);
`ifdef PARAFUZZ_LAG_TIMEOUT_EN
        wait_until(p + 16);
        chk("timeout_early", 64'(err_timeout), 64'd0);
        wait_until(p + 17);
        chk("timeout_set", 64'(err_timeout), 64'd1);
`else
        wait_until(p + 17);
        chk("timeout_absent", 64'(err_timeout), 64'd0);
`endif
        // Mid-operation reset discards the queued DUT markers
        do_reset();
        chk_idle("midreset");
        drive(1'b0, 32'd0, 1'b1, mk[0]);
        repeat (4) tick();
        chk("midreset_vnt_phase", 64'(vnt_phase), 64'd0);
        chk("midreset_sync", 64'(sync), 64'd0);
        do_reset();

        // Divergent codes
        drive(1'b1, MK_DELAY_START, 1'b1, MK_TEXE_START);
        tick();
        chk("div_err", 64'(err_diverge), 64'd1);
        chk("div_sync", 64'(sync), 64'd0);
        chk("div_dut_phase", 64'(dut_phase), 64'd1);
        chk("div_vnt_phase", 64'(vnt_phase), 64'd2);
        repeat (3) tick();
        chk("div_sticky", 64'(err_diverge), 64'd1);
        do_reset();

        // END with no open phase
        drive(1'b1, MK_VCTM_END, 1'b0, 32'd0);
        chk("proto_err", 64'(err_proto), 64'd1);
        chk("proto_phase", 64'(dut_phase), 64'd7);
        repeat (3) tick();
        do_reset();
        chk_idle("final_reset");

        repeat (3) tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
